// File: rtl/rgb_pwm_meter.sv
// Measures the high-cycle duty of one selected LED's R/G/B PWM lines over a
// fixed window and reports the triple with a valid strobe and a changed flag.
module rgb_pwm_meter #(
    parameter int WINDOW = 256,
    parameter int DW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    sel,
    input  logic [3:0]    R,
    input  logic [3:0]    G,
    input  logic [3:0]    B,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic          valid,
    output logic          changed,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [DW-1:0] duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;
    logic          first_q, first_d;

    logic [DW-1:0] sum_r, sum_g, sum_b;
    logic          last_sample;

    always_comb begin
        sum_r       = acc_r_q + DW'(R[sel_q]);
        sum_g       = acc_g_q + DW'(G[sel_q]);
        sum_b       = acc_b_q + DW'(B[sel_q]);
        last_sample = (cnt_q == DW'(WINDOW - 1));

        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        acc_r_d   = acc_r_q;
        acc_g_d   = acc_g_q;
        acc_b_d   = acc_b_q;
        duty_r_d  = duty_r_q;
        duty_g_d  = duty_g_q;
        duty_b_d  = duty_b_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        first_d   = first_q;

        case (state_q)
            IDLE, REPORT: begin
                cnt_d   = '0;
                acc_r_d = '0;
                acc_g_d = '0;
                acc_b_d = '0;
                if (en) begin
                    sel_d   = sel;
                    state_d = MEASURE;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (!en) begin
                    // Abort keeps the last report and the first-report flag untouched
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_r_d = '0;
                    acc_g_d = '0;
                    acc_b_d = '0;
                end else if (last_sample) begin
                    // duty_*_q doubles as the previous report for change detection
                    duty_r_d  = sum_r;
                    duty_g_d  = sum_g;
                    duty_b_d  = sum_b;
                    valid_d   = 1'b1;
                    changed_d = first_q || (sum_r != duty_r_q) ||
                                (sum_g != duty_g_q) || (sum_b != duty_b_q);
                    first_d   = 1'b0;
                    state_d   = REPORT;
                end else begin
                    acc_r_d = sum_r;
                    acc_g_d = sum_g;
                    acc_b_d = sum_b;
                    cnt_d   = cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            acc_r_q   <= '0;
            acc_g_q   <= '0;
            acc_b_q   <= '0;
            duty_r_q  <= '0;
            duty_g_q  <= '0;
            duty_b_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            acc_r_q   <= acc_r_d;
            acc_g_q   <= acc_g_d;
            acc_b_q   <= acc_b_d;
            duty_r_q  <= duty_r_d;
            duty_g_q  <= duty_g_d;
            duty_b_q  <= duty_b_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            first_q   <= first_d;
        end
    end

    assign duty_r  = duty_r_q;
    assign duty_g  = duty_g_q;
    assign duty_b  = duty_b_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign busy    = (state_q == MEASURE);

endmodule

// File: tb/tb_rgb_pwm_meter.sv
// Directed bench for rgb_pwm_meter: WINDOW=8 instance checked through an
// expected-report scoreboard, plus a default WINDOW=256 instance for the full-scale case.
module tb_rgb_pwm_meter;

    typedef struct {
        int r;
        int g;
        int b;
        int chg;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] R = 4'd0, G = 4'd0, B = 4'd0;
    logic [3:0] duty_r, duty_g, duty_b;
    logic       valid, changed, busy;

    logic       en2 = 1'b0;
    logic [1:0] sel2 = 2'd0;
    logic [3:0] R2 = 4'd0, G2 = 4'd0, B2 = 4'd0;
    logic [8:0] duty_r2, duty_g2, duty_b2;
    logic       valid2, changed2, busy2;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    rgb_pwm_meter #(.WINDOW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .R(R), .G(G), .B(B),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .valid(valid), .changed(changed), .busy(busy)
    );

    rgb_pwm_meter dut256 (
        .clk(clk), .rst(rst), .en(en2), .sel(sel2), .R(R2), .G(G2), .B(B2),
        .duty_r(duty_r2), .duty_g(duty_g2), .duty_b(duty_b2),
        .valid(valid2), .changed(changed2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] s,
                                 input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        en  = e;
        sel = s;
        R   = r;
        G   = g;
        B   = b;
    endtask

    // Scoreboard monitor: every valid strobe must match the oldest expected report
    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            checkOutput("valid_not_consecutive", prev_valid, 1'b0);
            checkOutput("report_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("report_cycle", cyc, e.cyc);
                checkOutput("duty_r", duty_r, e.r);
                checkOutput("duty_g", duty_g, e.g);
                checkOutput("duty_b", duty_b, e.b);
                checkOutput("changed", changed, e.chg);
            end
        end
        prev_valid = valid;
    end

    initial begin
        int k;
        int got;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_duty_r", duty_r, 0);
        checkOutput("reset_duty_g", duty_g, 0);
        checkOutput("reset_duty_b", duty_b, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_changed", changed, 0);
        checkOutput("reset_busy", busy, 0);

        // Static red on LED0, two back-to-back windows
        applyStimulus(1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        k = cyc + 1;
        sb.push_back('{8, 0, 0, 1, k + 8});
        sb.push_back('{8, 0, 0, 0, k + 17});
        tick();
        checkOutput("busy_after_enable", busy, 1);
        waitCyc(k + 17);
        en = 1'b0;
        tick();
        tick();
        checkOutput("busy_idle_after_stop", busy, 0);

        // LED2: green toggling, red high for first 3 samples, noise on other LEDs
        applyStimulus(1'b1, 2'd2, 4'b0001, 4'b0000, 4'b1011);
        k = cyc + 1;
        sb.push_back('{3, 4, 0, 1, k + 8});
        tick();
        for (int i = 0; i < 8; i++) begin
            R = (i < 3) ? 4'b0101 : 4'b0001;
            G = ((i % 2) == 0) ? 4'b0100 : 4'b1011;
            tick();
        end
        en = 1'b0;
        tick();
        tick();

        // sel switches 0 -> 3 mid-window
        applyStimulus(1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000);
        k = cyc + 1;
        sb.push_back('{8, 0, 0, 1, k + 8});
        sb.push_back('{0, 0, 0, 1, k + 17});
        waitCyc(k + 3);
        sel = 2'd3;
        waitCyc(k + 17);
        en = 1'b0;
        tick();
        tick();

        // Abort after 5 samples, then a full fresh window
        applyStimulus(1'b1, 2'd1, 4'b1111, 4'b0000, 4'b1111);
        k = cyc + 1;
        waitCyc(k + 5);
        checkOutput("busy_before_abort", busy, 1);
        en = 1'b0;
        tick();
        checkOutput("busy_after_abort", busy, 0);
        checkOutput("abort_hold_duty_r", duty_r, 0);
        checkOutput("abort_hold_duty_b", duty_b, 0);
        tick();
        en = 1'b1;
        k = cyc + 1;
        sb.push_back('{8, 0, 8, 1, k + 8});
        waitCyc(k + 8);
        en = 1'b0;
        tick();
        tick();
        checkOutput("hold_between_reports", duty_b, 8);

        // Reset mid-window: outputs cleared, next identical report still flagged changed
        en = 1'b1;
        k = cyc + 1;
        waitCyc(k + 3);
        rst = 1'b1;
        tick();
        checkOutput("midreset_duty_r", duty_r, 0);
        checkOutput("midreset_duty_b", duty_b, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_valid", valid, 0);
        rst = 1'b0;
        k = cyc + 1;
        sb.push_back('{8, 0, 8, 1, k + 8});
        waitCyc(k + 8);
        en = 1'b0;
        tick();
        tick();
        checkOutput("scoreboard_drained", sb.size(), 0);

        // Full-scale window on the default-sized instance
        en2  = 1'b1;
        sel2 = 2'd1;
        R2   = 4'b1101;
        G2   = 4'b0000;
        B2   = 4'b0010;
        k    = cyc + 1;
        got  = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            tick();
            if (valid2) got = 1;
        end
        checkOutput("w256_valid_seen", got, 1);
        checkOutput("w256_cycle", cyc, k + 256);
        checkOutput("w256_duty_b", duty_b2, 256);
        checkOutput("w256_duty_r", duty_r2, 0);
        checkOutput("w256_duty_g", duty_g2, 0);
        checkOutput("w256_changed", changed2, 1);
        en2 = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_meter.md
# rgb_pwm_meter

Receive-side companion to the LED controller: samples the 4-bit R, G and B PWM drive buses and measures the duty of one selected LED's three channels over a fixed window of clock cycles. Each completed window produces a registered duty triple, a one-cycle `valid` strobe and a `changed` flag. The block sits between the LED controller outputs and any self-check or display logic that must recover the colour being driven.

## Interface
- `WINDOW`, 256: number of sampled cycles per measurement window; must be ≥2.
- `DW`, `$clog2(WINDOW+1)`: duty output width; holds the values 0..WINDOW.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; measurement proceeds while high.
- `sel`  in  2  LED index 0..3 whose channels are measured.
- `R`  in  4  red PWM lines, bit i = LED i.
- `G`  in  4  green PWM lines, bit i = LED i.
- `B`  in  4  blue PWM lines, bit i = LED i.
- `duty_r`  out  DW  high-cycle count of `R[sel]` in the last completed window.
- `duty_g`  out  DW  same for `G[sel]`.
- `duty_b`  out  DW  same for `B[sel]`.
- `valid`  out  1  one-cycle strobe: new duty triple loaded.
- `changed`  out  1  qualified by `valid`; the triple differs from the previous report.
- `busy`  out  1  high while in MEASURE.

## Operation
- The `R`, `G` and `B` inputs are synchronous to `clk`. No input synchroniser is used.
- FSM states:
  - IDLE: on reset. Cycle counter and accumulators cleared. If `en`=1, capture `sel` into `sel_q` and go to MEASURE.
  - MEASURE: each cycle, sample `R[sel_q]`, `G[sel_q]` and `B[sel_q]`. Add each bit to its accumulator and increment the cycle counter.
  - MEASURE exit: on the edge taking sample number WINDOW, load `duty_*` with the final totals. Set `valid`=1 and `changed` per the rule below, store the triple as the previous report, and go to REPORT.
  - REPORT: lasts one cycle, with no sampling. Clear the counter and accumulators. If `en`=1, recapture `sel` and go to MEASURE; otherwise go to IDLE.
- `sel` changes during MEASURE are ignored; they take effect at the next window start.
- If `en`=0 is seen in MEASURE, abort: go to IDLE with no `valid`. `duty_*` and the previous report hold their values.
- `changed`=1 when any of `duty_r`, `duty_g` or `duty_b` differs from the previous report.
  - The first report after reset always has `changed`=1; a first-report flag is cleared by that report.
  - An abort does not re-arm the first-report flag.
- Arithmetic:
  - Accumulators are DW bits wide and saturate-free by construction, since the maximum is WINDOW.
  - An all-high line reports exactly WINDOW; an all-low line reports 0.
- `busy` = (state == MEASURE).

## Timing
- Reset values: `duty_r` = `duty_g` = `duty_b` = 0; `valid` = 0; `changed` = 0; `busy` = 0; state IDLE; first-report flag set.
- Reset mid-window discards the partial window. `rst` has priority over every other event.
- `en` sampled high at edge k:
  - MEASURE from edge k; `busy`=1 from edge k.
  - Samples are taken at edges k+1 … k+WINDOW.
  - `duty_*` update and `valid`=1 at edge k+WINDOW, for one cycle.
- With `en` held high, windows repeat every WINDOW+1 cycles, so `valid` strobes are spaced WINDOW+1 cycles apart.
- `valid` is never high for two consecutive cycles.
- Outputs are registered. `duty_*` are stable between strobes.

## Test plan
- Static channels, WINDOW=8, `sel`=0, `R`=4'b0001, `G`=`B`=0, `en` rises at edge k -> at edge k+8: `duty_r`=8, `duty_g`=0, `duty_b`=0, `valid`=1 for one cycle, `changed`=1; next strobe at k+17 with `changed`=0.
- 50% PWM, WINDOW=8, `sel`=2, `G[2]` toggling every cycle, `R[2]`=1 for the first 3 samples only -> `duty_g`=4, `duty_r`=3, `duty_b`=0.
- `sel` switches from 0 to 3 mid-window, with `R[0]`=1 and `R[3]`=0 -> current report `duty_r`=8; the following window reports 0 with `changed`=1.
- `en` dropped after 5 samples -> no `valid`; `busy` falls next edge; `duty_*` keep their prior values; re-enable gives a full fresh window.
- `rst` pulsed mid-window after a previous report -> all outputs 0; the next report has `changed`=1 even if values equal the pre-reset report.
- `B[1]` all high, `sel`=1, default WINDOW=256 -> `duty_b`=256 (9-bit), with no overflow.
